// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg: shared state, opcode and trap-cause definitions for the rv32 control path
package core_ctrl_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_FETCH  = 3'd0;
  localparam state_t S_DECODE = 3'd1;
  localparam state_t S_EXEC   = 3'd2;
  localparam state_t S_MEM    = 3'd3;
  localparam state_t S_WB     = 3'd4;
  localparam state_t S_TRAP   = 3'd5;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_ILLEGAL = 2'd1,
    CAUSE_IMEM_TO = 2'd2,
    CAUSE_DMEM_TO = 2'd3
  } trap_cause_e;
  function automatic logic opc_legal(input logic [6:0] op);
    return op inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
                      OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_FENCE, OPC_SYSTEM};
  endfunction
endpackage

// File: rtl/bus_watchdog.sv
// bus_watchdog: counts unacknowledged request cycles and flags expiry at LIMIT (0 disables)
module bus_watchdog #(
  parameter int LIMIT = 255,
  parameter int W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic req,
  input  logic ack,
  output logic expired
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (req && !ack && cnt != W'(LIMIT)) cnt <= cnt + 1'b1;
  end
  assign expired = (LIMIT != 0) && req && !ack && cnt == W'(LIMIT);
endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle rv32 control FSM; define CORE_SEQ_INSTRET_EN to add the instret counter
module core_sequencer
  import core_ctrl_pkg::*;
#(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [4:0] rd,
  input  logic       branch_taken,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  output logic       imem_req,
  output logic       ir_load,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       reg_write,
  output logic       pc_write,
  output logic       pc_sel_target,
  output logic [2:0] state_o,
  output logic       trap,
  output logic [1:0] trap_cause
`ifdef CORE_SEQ_INSTRET_EN
  , output logic [31:0] instret
`endif
);
  localparam int TO_W = BUS_TIMEOUT > 0 ? $clog2(BUS_TIMEOUT + 1) : 1;
  state_t state, nxt;
  trap_cause_e cause, cause_nxt;
  logic expired, is_br, is_ld, is_st, is_jmp, is_nop, in_f, in_m, run;
  assign is_br  = opcode == OPC_BRANCH;
  assign is_ld  = opcode == OPC_LOAD;
  assign is_st  = opcode == OPC_STORE;
  assign is_jmp = opcode == OPC_JAL || opcode == OPC_JALR;
  assign is_nop = opcode == OPC_FENCE || opcode == OPC_SYSTEM;
  assign in_f   = state == S_FETCH;
  assign in_m   = state == S_MEM;
  assign run    = !rst;
  always_comb begin
    nxt = state;
    cause_nxt = cause;
    case (state)
      S_FETCH: begin
        if (imem_ack) nxt = S_DECODE;
        else if (expired) begin
          nxt = S_TRAP;
          cause_nxt = CAUSE_IMEM_TO;
        end
      end
      S_DECODE: begin
        nxt = opc_legal(opcode) ? S_EXEC : S_TRAP;
        cause_nxt = opc_legal(opcode) ? cause : CAUSE_ILLEGAL;
      end
      S_EXEC: nxt = (is_br || is_nop) ? S_FETCH : (is_ld || is_st) ? S_MEM : S_WB;
      S_MEM: begin
        if (dmem_ack) nxt = is_st ? S_FETCH : S_WB;
        else if (expired) begin
          nxt = S_TRAP;
          cause_nxt = CAUSE_DMEM_TO;
        end
      end
      S_WB: nxt = S_FETCH;
      default: nxt = S_TRAP;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      cause <= CAUSE_NONE;
    end else begin
      state <= nxt;
      cause <= cause_nxt;
    end
  end
  // FETCH and MEM never overlap, so one counter serves both; leaving a state restarts it
  bus_watchdog #(.LIMIT(BUS_TIMEOUT), .W(TO_W)) u_wdog (
    .clk(clk),
    .rst(rst),
    .clr(nxt != state),
    .req(in_f || in_m),
    .ack(in_f ? imem_ack : dmem_ack),
    .expired(expired)
  );
  assign imem_req      = run && in_f;
  assign ir_load       = imem_req && imem_ack;
  assign dmem_req      = run && in_m;
  assign dmem_we       = dmem_req && is_st;
  assign reg_write     = run && state == S_WB && rd != 5'd0;
  assign pc_write      = run && (state == S_WB || (state == S_EXEC && (is_br || is_nop)) ||
                                 (dmem_we && dmem_ack));
  assign pc_sel_target = run && ((state == S_EXEC && is_br && branch_taken) ||
                                 (state == S_WB && is_jmp));
  assign state_o       = run ? state : S_FETCH;
  assign trap          = run && state == S_TRAP;
  assign trap_cause    = run ? cause : CAUSE_NONE;
`ifdef CORE_SEQ_INSTRET_EN
  logic [31:0] instret_q;
  always_ff @(posedge clk) begin
    if (rst) instret_q <= '0;
    else if (pc_write) instret_q <= instret_q + 32'd1;
  end
  assign instret = run ? instret_q : 32'd0;
`endif
endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: scoreboard bench for core_sequencer with BUS_TIMEOUT=4
module tb_core_sequencer;
  localparam logic [2:0] SF = 3'd0, SD = 3'd1, SE = 3'd2, SM = 3'd3, SW = 3'd4, ST = 3'd5;
  localparam logic [7:0] F_IREQ = 8'h80, F_IRL = 8'h40, F_DREQ = 8'h20, F_DWE = 8'h10;
  localparam logic [7:0] F_RW = 8'h08, F_PW = 8'h04, F_PS = 8'h02, F_TR = 8'h01;
  localparam logic [6:0] OP_IMM = 7'b0010011, OP_BR = 7'b1100011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_FENCE = 7'b0001111, OP_LUI = 7'b0110111, OP_OP = 7'b0110011;
  localparam logic [6:0] OP_BAD = 7'b1111111;
  logic clk = 0, rst = 1, branch_taken = 0, imem_ack = 0, dmem_ack = 0;
  logic [6:0] opcode = '0;
  logic [4:0] rd = '0;
  logic imem_req, ir_load, dmem_req, dmem_we, reg_write, pc_write, pc_sel_target, trap;
  logic [2:0] state_o;
  logic [1:0] trap_cause;
`ifdef CORE_SEQ_INSTRET_EN
  logic [31:0] instret;
`endif
  int checks = 0, errors = 0;
  logic [6:0] cur_op = '0;
  logic [4:0] cur_rd = '0;
  typedef struct {
    string tag;
    logic [12:0] e;
  } sb_t;
  sb_t sb[$];
  sb_t item;

  core_sequencer #(.BUS_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .rd(rd), .branch_taken(branch_taken),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .ir_load(ir_load),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_write(reg_write), .pc_write(pc_write),
    .pc_sel_target(pc_sel_target), .state_o(state_o), .trap(trap), .trap_cause(trap_cause)
`ifdef CORE_SEQ_INSTRET_EN
    , .instret(instret)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] ev(input logic [2:0] s, input logic [7:0] f, input logic [1:0] c);
    return {s, f, c};
  endfunction

  task automatic cyc(input string tag, input logic r, input logic ia, input logic da,
                     input logic bt, input logic [12:0] e);
    sb_t x;
    @(negedge clk);
    rst = r; opcode = cur_op; rd = cur_rd; branch_taken = bt; imem_ack = ia; dmem_ack = da;
    x.tag = tag;
    x.e = e;
    sb.push_back(x);
  endtask

  task automatic fetch(input string tag, input logic [6:0] op, input logic [4:0] r);
    cur_op = op;
    cur_rd = r;
    cyc(tag, 0, 1, 0, 0, ev(SF, F_IREQ | F_IRL, 2'd0));
  endtask

  task automatic alu(input string tag, input logic [6:0] op, input logic [4:0] r, input logic [7:0] wb);
    fetch({tag, "_f"}, op, r);
    cyc({tag, "_d"}, 0, 0, 0, 0, ev(SD, 8'h00, 2'd0));
    cyc({tag, "_e"}, 0, 0, 0, 0, ev(SE, 8'h00, 2'd0));
    cyc({tag, "_w"}, 0, 0, 0, 0, ev(SW, wb, 2'd0));
  endtask

  always @(negedge clk) begin
    #2;
    if (sb.size() != 0) begin
      item = sb.pop_front();
      check(item.tag, 32'({state_o, imem_req, ir_load, dmem_req, dmem_we, reg_write, pc_write,
                           pc_sel_target, trap, trap_cause}), 32'(item.e));
    end
  end

  initial begin
    cyc("rst", 1, 0, 0, 0, ev(SF, 8'h00, 2'd0));
    cyc("rst_hold", 1, 1, 1, 1, ev(SF, 8'h00, 2'd0));
    alu("opimm", OP_IMM, 5'd5, F_RW | F_PW);
    fetch("br1_f", OP_BR, 5'd3);
    cyc("br1_d_ignack", 0, 1, 1, 1, ev(SD, 8'h00, 2'd0));
    cyc("br1_e", 0, 0, 0, 1, ev(SE, F_PW | F_PS, 2'd0));
    fetch("br0_f", OP_BR, 5'd3);
    cyc("br0_d", 0, 0, 0, 0, ev(SD, 8'h00, 2'd0));
    cyc("br0_e", 0, 0, 0, 0, ev(SE, F_PW, 2'd0));
    fetch("ld_f", OP_LD, 5'd0);
    cyc("ld_d", 0, 0, 0, 0, ev(SD, 8'h00, 2'd0));
    cyc("ld_e", 0, 0, 1, 0, ev(SE, 8'h00, 2'd0));
    repeat (3) cyc("ld_mwait", 0, 0, 0, 0, ev(SM, F_DREQ, 2'd0));
    cyc("ld_mack", 0, 0, 1, 0, ev(SM, F_DREQ, 2'd0));
    cyc("ld_w", 0, 0, 0, 0, ev(SW, F_PW, 2'd0));
    alu("jal", OP_JAL, 5'd1, F_RW | F_PW | F_PS);
    alu("jalr0", OP_JALR, 5'd0, F_PW | F_PS);
    alu("lui", OP_LUI, 5'd7, F_RW | F_PW);
    fetch("st_f", OP_ST, 5'd9);
    cyc("st_d", 0, 0, 0, 0, ev(SD, 8'h00, 2'd0));
    cyc("st_e", 0, 0, 0, 0, ev(SE, 8'h00, 2'd0));
    cyc("st_m", 0, 0, 1, 0, ev(SM, F_DREQ | F_DWE | F_PW, 2'd0));
    fetch("fence_f", OP_FENCE, 5'd2);
    cyc("fence_d", 0, 0, 0, 0, ev(SD, 8'h00, 2'd0));
    cyc("fence_e", 0, 0, 0, 0, ev(SE, F_PW, 2'd0));
    repeat (5) cyc("ito_wait", 0, 0, 0, 0, ev(SF, F_IREQ, 2'd0));
    cyc("ito_trap", 0, 1, 0, 0, ev(ST, F_TR, 2'd2));
    cyc("ito_rst", 1, 0, 0, 0, ev(SF, 8'h00, 2'd0));
    repeat (4) cyc("late_wait", 0, 0, 0, 0, ev(SF, F_IREQ, 2'd0));
    alu("late", OP_OP, 5'd0, F_PW);
    fetch("dto_f", OP_ST, 5'd4);
    cyc("dto_d", 0, 0, 0, 0, ev(SD, 8'h00, 2'd0));
    cyc("dto_e", 0, 0, 0, 0, ev(SE, 8'h00, 2'd0));
    repeat (5) cyc("dto_wait", 0, 0, 0, 0, ev(SM, F_DREQ | F_DWE, 2'd0));
    cyc("dto_trap", 0, 0, 1, 0, ev(ST, F_TR, 2'd3));
    cyc("dto_rst", 1, 0, 0, 0, ev(SF, 8'h00, 2'd0));
    fetch("ill_f", OP_BAD, 5'd1);
    cyc("ill_d", 0, 0, 0, 0, ev(SD, 8'h00, 2'd0));
    repeat (20) cyc("ill_trap", 0, 1, 1, 1, ev(ST, F_TR, 2'd1));
    cyc("ill_rst", 1, 0, 0, 0, ev(SF, 8'h00, 2'd0));
    cyc("ill_rel", 0, 0, 0, 0, ev(SF, F_IREQ, 2'd0));
    fetch("rm_f", OP_ST, 5'd6);
    cyc("rm_d", 0, 0, 0, 0, ev(SD, 8'h00, 2'd0));
    cyc("rm_e", 0, 0, 0, 0, ev(SE, 8'h00, 2'd0));
    cyc("rm_m", 0, 0, 0, 0, ev(SM, F_DREQ | F_DWE, 2'd0));
    cyc("rm_abort", 1, 0, 1, 0, ev(SF, 8'h00, 2'd0));
    cyc("rm_rel", 0, 0, 0, 0, ev(SF, F_IREQ, 2'd0));
`ifdef CORE_SEQ_INSTRET_EN
    check("instret_rst", instret, 32'd0);
`endif
    repeat (3) alu("ret", OP_IMM, 5'd8, F_RW | F_PW);
    cyc("ret_idle", 0, 0, 0, 0, ev(SF, F_IREQ, 2'd0));
`ifdef CORE_SEQ_INSTRET_EN
    check("instret_3", instret, 32'd3);
`endif
    @(negedge clk);
    #3;
    if (sb.size() != 0) check("sb_drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
- Multi-cycle control FSM for the rv32 core.
- Sequences one instruction at a time through fetch, decode, execute, memory and writeback.
- Drives the instruction-register load, the register-file write enable (RegWrite into the decode stage), the data-memory request and the PC update.
- Sits beside the decode datapath, consumes its opcode/rd fields, and handshakes with instruction and data memories via req/ack.

Parameters:
- BUS_TIMEOUT, 255: max cycles a memory request may wait for ack before trapping; 0 disables the timeout.
- TO_W, $clog2(BUS_TIMEOUT+1) (min 1): width of the wait counter (localparam).

Ports:
- clk  in  1  core clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  7  instruction[6:0] from decoder.
- rd  in  5  destination register field from decoder.
- branch_taken  in  1  ALU compare result, valid in EXEC.
- imem_ack  in  1  instruction memory data valid.
- dmem_ack  in  1  data memory access complete.
- imem_req  out  1  instruction fetch request.
- ir_load  out  1  latch fetched word into the instruction register.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write (store).
- reg_write  out  1  register-file write enable (RegWrite).
- pc_write  out  1  update PC this cycle.
- pc_sel_target  out  1  1 = PC takes branch/jump target; 0 = PC+4.
- state_o  out  3  current state encoding, for debug.
- trap  out  1  core halted.
- trap_cause  out  2  0 none, 1 illegal opcode, 2 imem timeout, 3 dmem timeout.

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Encodings are fixed.
- Reset: state<=FETCH, trap_cause<=0, wait counter<=0. While rst=1, all outputs are 0. imem_req rises in the first cycle after rst falls.
- Outputs are Moore-decoded from state, except ir_load, reg_write and pc_write, which qualify on the current ack/opcode as listed.
- FETCH: imem_req=1. On imem_ack: ir_load=1, go to DECODE. An ack in the same cycle as req is legal, giving a 1-cycle fetch.
- DECODE (1 cycle): classify opcode.
  - Legal: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011.
  - FENCE 0001111 and SYSTEM 1110011 execute as no-ops.
  - Anything else: go to TRAP with cause 1.
- EXEC (1 cycle):
  - BRANCH: pc_write=1, pc_sel_target=branch_taken, go to FETCH.
  - LOAD/STORE: go to MEM.
  - FENCE/SYSTEM: pc_write=1, pc_sel_target=0, go to FETCH.
  - Others: go to WB.
- MEM: dmem_req=1; dmem_we=1 for STORE only. On dmem_ack:
  - LOAD: go to WB.
  - STORE: pc_write=1, go to FETCH.
- WB (1 cycle): reg_write=(rd!=0); pc_write=1; pc_sel_target=1 for JAL/JALR, else 0; go to FETCH.
- Zero-wait latencies: ALU/LUI/AUIPC/JAL/JALR take 4 cycles; BRANCH 3; STORE 4; LOAD 5.
- Timeout:
  - Wait counter clears on entry to FETCH/MEM and increments each cycle the req is high without ack.
  - When count==BUS_TIMEOUT and there is still no ack, go to TRAP with cause 2 (FETCH) or 3 (MEM).
  - An ack in that same cycle wins; no trap.
- TRAP: trap=1; all strobes 0; absorbing until rst.
- Acks arriving while the matching req is 0 are ignored.
- opcode and rd must be stable from DECODE through WB; the sequencer does not re-latch them.
- Reset mid-MEM or mid-FETCH aborts the access. No pc_write or reg_write is issued for the aborted instruction.

Optional Feature:
- CORE_SEQ_INSTRET_EN: adds output instret [31:0].
  - Reset 0; increments by 1 on every cycle where pc_write=1 (instruction retired).
  - Wraps 0xFFFFFFFF -> 0.
  - Frozen in TRAP.
- Without the macro, the port and counter are absent.

Decomposition:
- Package core_ctrl_pkg: state enum, opcode localparams (OPC_LUI ... OPC_SYSTEM), trap_cause enum. Shared with decoder/ALU control.
- One sub-module, bus_watchdog:
  - Inputs: clk, rst, clr, req, ack. Parameter: LIMIT.
  - Output: expired.
  - Instantiated once and shared, since FETCH and MEM are mutually exclusive.

Test Plan:
- OP-IMM (0010011, rd=5), imem_ack same cycle as req -> states 0,1,2,4; reg_write=1 and pc_write=1 in cycle 4 only; 4 cycles total.
- BRANCH with branch_taken=1 then 0 -> pc_write=1 in EXEC with pc_sel_target=1 then 0; reg_write never asserted.
- LOAD, dmem_ack delayed 3 cycles, rd=0 -> dmem_req high 4 cycles, dmem_we=0, WB has reg_write=0, pc_write=1.
- Opcode 1111111 -> TRAP, trap=1, trap_cause=1; imem_req stays 0 for 20 cycles; rst returns to FETCH.
- BUS_TIMEOUT=4, imem_ack never -> trap_cause=2 after 5 req cycles. Repeat with ack in the 5th cycle -> no trap.
- rst pulsed during MEM of a STORE -> no pc_write; next cycle after release imem_req=1. With CORE_SEQ_INSTRET_EN, instret=0 after reset and 3 after three retired ALU ops.
